// File: rtl/tone_freq_meter.sv
// Tone PWM meter: gated edge count gives frequency; rise-to-rise timing gives period and high time.
// Input is synchronized with two flops; silence is declared after TIMEOUT_CYCLES without a rise.
module tone_freq_meter #(
  parameter int unsigned CLK_HZ         = 100_000_000,
  parameter int unsigned GATE_DIV       = 8,
  parameter int unsigned TIMEOUT_CYCLES = 2_000_000,
  parameter int unsigned CNT_W          = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             pwm_in,
  output logic [CNT_W-1:0] freq_hz,
  output logic             freq_valid,
  output logic [CNT_W-1:0] period_cycles,
  output logic [CNT_W-1:0] high_cycles,
  output logic             per_valid,
  output logic             silent
);

  localparam int unsigned      GATE_CYCLES = CLK_HZ / GATE_DIV;
  localparam logic [CNT_W-1:0] GateLast    = CNT_W'(GATE_CYCLES - 1);
  localparam logic [CNT_W-1:0] GateMul     = CNT_W'(GATE_DIV);
  localparam logic [CNT_W-1:0] Timeout     = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] One         = CNT_W'(1);
  localparam logic [CNT_W-1:0] CntMax      = '1;

  logic s1_q, s2_q, prev_q;
  logic rise, fall, gate_tc;
  logic [CNT_W-1:0] gate_cnt_q, gate_cnt_d;
  logic [CNT_W-1:0] edge_cnt_q, edge_cnt_d;
  logic [CNT_W-1:0] freq_q, freq_d;
  logic             freq_valid_q, freq_valid_d;
  logic [CNT_W-1:0] since_rise_q, since_rise_d;
  logic [CNT_W-1:0] high_run_q, high_run_d;
  logic [CNT_W-1:0] high_lat_q, high_lat_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic [CNT_W-1:0] high_q, high_d;
  logic             per_valid_q, per_valid_d;
  logic             silent_q, silent_d;
  logic             armed_q, armed_d;

  always_comb begin
    rise    = s2_q & ~prev_q;
    fall    = ~s2_q & prev_q;
    gate_tc = (gate_cnt_q == GateLast);

    gate_cnt_d   = gate_tc ? '0 : gate_cnt_q + One;
    edge_cnt_d   = edge_cnt_q;
    freq_d       = freq_q;
    freq_valid_d = 1'b0;
    if (gate_tc) begin
      // A rise in the terminal cycle belongs to the closing gate.
      freq_d       = (edge_cnt_q + CNT_W'(rise)) * GateMul;
      freq_valid_d = 1'b1;
      edge_cnt_d   = '0;
    end else if (rise && edge_cnt_q != CntMax) begin
      edge_cnt_d = edge_cnt_q + One;
    end

    since_rise_d = since_rise_q;
    high_run_d   = high_run_q;
    if (rise) begin
      since_rise_d = One;
      high_run_d   = One;
    end else begin
      if (since_rise_q != CntMax) since_rise_d = since_rise_q + One;
      if (s2_q && high_run_q != CntMax) high_run_d = high_run_q + One;
    end
    high_lat_d = fall ? high_run_q : high_lat_q;

    period_d    = period_q;
    high_d      = high_q;
    per_valid_d = 1'b0;
    silent_d    = silent_q;
    armed_d     = armed_q;
    if (rise) begin
      if (armed_q) begin
        period_d    = since_rise_q;
        high_d      = high_lat_q;
        per_valid_d = 1'b1;
        silent_d    = 1'b0;
      end else begin
        armed_d = 1'b1;
      end
    end else if (armed_q && since_rise_q >= Timeout) begin
      silent_d = 1'b1;
      period_d = '0;
      high_d   = '0;
      armed_d  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_q         <= 1'b0;
      s2_q         <= 1'b0;
      prev_q       <= 1'b0;
      gate_cnt_q   <= '0;
      edge_cnt_q   <= '0;
      freq_q       <= '0;
      freq_valid_q <= 1'b0;
      since_rise_q <= '0;
      high_run_q   <= '0;
      high_lat_q   <= '0;
      period_q     <= '0;
      high_q       <= '0;
      per_valid_q  <= 1'b0;
      silent_q     <= 1'b1;
      armed_q      <= 1'b0;
    end else begin
      s1_q         <= pwm_in;
      s2_q         <= s1_q;
      prev_q       <= s2_q;
      gate_cnt_q   <= gate_cnt_d;
      edge_cnt_q   <= edge_cnt_d;
      freq_q       <= freq_d;
      freq_valid_q <= freq_valid_d;
      since_rise_q <= since_rise_d;
      high_run_q   <= high_run_d;
      high_lat_q   <= high_lat_d;
      period_q     <= period_d;
      high_q       <= high_d;
      per_valid_q  <= per_valid_d;
      silent_q     <= silent_d;
      armed_q      <= armed_d;
    end
  end

  assign freq_hz       = freq_q;
  assign freq_valid    = freq_valid_q;
  assign period_cycles = period_q;
  assign high_cycles   = high_q;
  assign per_valid     = per_valid_q;
  assign silent        = silent_q;

endmodule
